// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial nibble adder.
//   NIBBLE_W : width of the single ripple adder slice
//   S_IDLE / S_RUN / S_DONE : FSM state encoding
//   clog2    : index-width helper, evaluated at elaboration time
package serial_adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

  // Smallest n with 2**n >= value; returns 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/four_bit_adder.sv
// Combinational 4-bit ripple-carry adder slice.
// Ports:
//   a, b : nibble operands
//   cin  : carry into bit 0
//   s    : nibble sum
//   c    : carry out of every bit; c[3] is the slice carry-out and c[2] the
//          carry into the MSB, together giving signed overflow
module four_bit_adder
  import serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic [NIBBLE_W-1:0] c
);

  always_comb begin
    logic carry;
    carry = cin;
    s     = '0;
    c     = '0;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      c[i]  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      carry = c[i];
    end
  end

endmodule

// File: rtl/serial_nibble_adder.sv
// Multi-cycle adder: one nibble per clock through a single four_bit_adder,
// with the carry held in carry_q between nibbles.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (in_ready high only in IDLE)
//   a, b, cin             : operands and carry-in, sampled on the accept edge
//   sub                   : subtract select, present only with SERIAL_ADDER_SUB_EN
//   out_valid / out_ready : result handshake (out_valid high only in DONE)
//   sum, cout, ovf        : result, MSB carry-out, signed overflow
// Configuration: define SERIAL_ADDER_SUB_EN to add the sub port (a - b).
module serial_nibble_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]   a,
  input  logic [NIBBLE_W*NIBBLES-1:0]   b,
  input  logic                          cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic                          sub,
`endif
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]   sum,
  output logic                          cout,
  output logic                          ovf
);

  localparam int unsigned W    = NIBBLE_W * NIBBLES;
  localparam int unsigned IdxW = (clog2(NIBBLES) < 1) ? 1 : clog2(NIBBLES);

  state_t state_q, state_d;

  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            carry_q, carry_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [NIBBLE_W-1:0] add_s;
  logic [NIBBLE_W-1:0] add_c;
  logic                last_nibble;
  logic [W-1:0]        cap_b;
  logic                cap_cin;
  logic                unused_c;

  // Only the top two carries of the slice matter at this level.
  assign unused_c = ^add_c[NIBBLE_W-3:0];

  assign last_nibble = (idx_q == IdxW'(NIBBLES - 1));

  // Operand conditioning at capture: subtraction is a + ~b + 1.
`ifdef SERIAL_ADDER_SUB_EN
  assign cap_b   = sub ? ~b : b;
  assign cap_cin = sub ? 1'b1 : cin;
`else
  assign cap_b   = b;
  assign cap_cin = cin;
`endif

  // Operands are shifted right so the active nibble is always at [3:0].
  four_bit_adder u_four_bit_adder (
    .a   (a_q[NIBBLE_W-1:0]),
    .b   (b_q[NIBBLE_W-1:0]),
    .cin (carry_q),
    .s   (add_s),
    .c   (add_c)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (last_nibble) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // Datapath next-state
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = cap_b;
          carry_d = cap_cin;
          idx_d   = '0;
        end
      end
      S_RUN: begin
        a_d     = a_q >> NIBBLE_W;
        b_d     = b_q >> NIBBLE_W;
        carry_d = add_c[NIBBLE_W-1];
        idx_d   = idx_q + 1'b1;
        sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = add_s;
        if (last_nibble) begin
          cout_d = add_c[NIBBLE_W-1];
          ovf_d  = add_c[NIBBLE_W-1] ^ add_c[NIBBLE_W-2];
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
